// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and mem_responder: one request in, one response out,
// each with its own valid/ready handshake.
interface mem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding word memory responder: response WAIT_CYCLES edges after acceptance, held until rsp_ready.
// Optional address/alignment error checking is enabled by defining MEM_RESP_ERR_EN.
module mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  mem_responder_if.slave   bus,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [3:0]     cnt;
  logic           cap_we;
  logic [31:0]    cap_addr;
  logic [31:0]    cap_wdata;
  logic [31:0]    mem [DEPTH];
  logic [31:0]    rdata_q;
  logic           err_q;

  logic           accept;
  logic           enter_rsp;
  logic           acc_we;
  logic [31:0]    acc_addr;
  logic [31:0]    acc_wdata;
  logic [AW-1:0]  acc_idx;
  logic           acc_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // req_ready is gated by reset so it stays low while reset is held.
  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    enter_rsp     = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    busy          = 1'b1;
    case (state)
      ST_IDLE: begin
        busy          = 1'b0;
        bus.req_ready = reset;
        if (bus.req_valid && reset) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt = ST_RESPOND;
            enter_rsp = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_RESPOND;
          enter_rsp = 1'b1;
        end
      end
      ST_RESPOND: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (accept) begin
      cap_we    <= bus.req_we;
      cap_addr  <= bus.req_addr;
      cap_wdata <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= CNT_LOAD;
    end else if (state == ST_WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // With zero wait states the access happens on the acceptance edge, so use the live request.
  always_comb begin
    if (state == ST_IDLE) begin
      acc_we    = bus.req_we;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
    end else begin
      acc_we    = cap_we;
      acc_addr  = cap_addr;
      acc_wdata = cap_wdata;
    end
  end

  assign acc_idx = acc_addr[AW+1:2];

`ifdef MEM_RESP_ERR_EN
  assign acc_err = (acc_addr[31:AW+2] != '0) || (acc_addr[1:0] != 2'b00);
`else
  // Upper and byte-offset bits are ignored: the word index wraps modulo DEPTH.
  logic unused_addr;
  assign unused_addr = ^{acc_addr[31:AW+2], acc_addr[1:0]};
  assign acc_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (enter_rsp && acc_we && !acc_err) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (enter_rsp) begin
      rdata_q <= (acc_we || acc_err) ? 32'd0 : mem[acc_idx];
      err_q   <= acc_err;
    end
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words stored; power of two, 4..256.
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted between request acceptance and response; range 0..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address; word index = req_addr[log2(DEPTH)+1:2].
REQ-008 req_wdata  input  32  store data.
REQ-009 req_ready  output  1  responder can accept a request this cycle.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  initiator accepts response.
REQ-012 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  request rejected (REQ-024).
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states IDLE, WAIT, RESPOND; encoding is free, and unreachable encodings return to IDLE.
REQ-016 IDLE: req_ready=1, rsp_valid=0; request accepted on an edge with req_valid=1, and req_we/req_addr/req_wdata are captured.
REQ-017 IDLE -> WAIT on acceptance when WAIT_CYCLES>0, with the wait counter loaded to WAIT_CYCLES-1; IDLE -> RESPOND directly when WAIT_CYCLES=0.
REQ-018 WAIT: req_ready=0; counter decrements each cycle; WAIT -> RESPOND on the edge where counter=0.
REQ-019 Memory access (store commit or load read) occurs on the edge entering RESPOND; rsp_rdata/rsp_err are registered at that edge.
REQ-020 Latency: request accepted at edge N -> rsp_valid=1 in the cycle after edge N+WAIT_CYCLES.
REQ-021 RESPOND: rsp_valid=1, req_ready=0; rsp_rdata/rsp_err held stable until an edge with rsp_ready=1, then -> IDLE.
REQ-022 No request is accepted in the same cycle a response completes; the next acceptance is no earlier than the following IDLE cycle.
REQ-023 Request inputs are ignored outside IDLE; changes to them do not affect the captured request.
REQ-024 Error (macro defined, see REQ-029): word index >= DEPTH (req_addr[31:log2(DEPTH)+2] != 0) or req_addr[1:0] != 0 -> no store, rsp_rdata=0, rsp_err=1.
REQ-025 A load of a word stored by the previous request returns the new data (write-before-read ordering across requests).

Reset
REQ-026 reset=0 forces, asynchronously: state IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=0, and all DEPTH words set to 0.
REQ-027 req_ready rises in the first cycle after reset deasserts.
REQ-028 Reset asserted in WAIT or RESPOND abandons the request; a store not yet committed is never written, and no response is produced after release.

Configuration
REQ-029 Macro MEM_RESP_ERR_EN: when defined, REQ-024 checking is active; when undefined, rsp_err is tied to 0, the upper address bits are ignored (the word index wraps modulo DEPTH), req_addr[1:0] is ignored, and every request accesses memory.

Verification
REQ-030 Reset release, WAIT_CYCLES=2, store addr 0x0000_0010 data 0xDEAD_BEEF accepted at edge N -> rsp_valid rises after edge N+2, rsp_err=0, rsp_rdata=0; a load of 0x10 then returns 0xDEAD_BEEF.
REQ-031 Load 0x0000_0004 with rsp_ready held 0 for 5 cycles -> rsp_valid stays 1 and rsp_rdata stays 0 (reset value) for all 5 cycles; req_ready=0 and busy=1 throughout; IDLE is re-entered one edge after rsp_ready=1.
REQ-032 With MEM_RESP_ERR_EN defined, DEPTH=64: store to 0x0000_0100 -> rsp_err=1 and memory unchanged; store to 0x0000_0002 -> rsp_err=1. With the macro undefined, a store to 0x0000_0100 writes word 0 and rsp_err=0.
REQ-033 WAIT_CYCLES=0, back-to-back loads with req_valid held 1 and rsp_ready held 1 -> one response per 2 cycles, and req_ready toggles 1,0,1,0.
REQ-034 Store of 0x1234_5678 to 0x20, with reset pulsed low during WAIT -> after release, a load of 0x20 returns 0 and no rsp_valid appears for the abandoned request.
REQ-035 Changing req_addr/req_wdata during WAIT -> response matches the values captured at acceptance.
